add49_share_arb: RTL
====================

Name: add49_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one 49-bit adder instance among NREQ requesters.
- Drives the adder's A/B operands from the granted requester.
- Registers the sum with a requester tag and returns it over a valid/ready response channel.
- Supports locked multi-beat bursts, so one requester can issue consecutive additions uninterrupted.

Parameters:
- WIDTH, 48: operand MSB index; operand and sum width is WIDTH+1 (49 bits).
- NREQ, 4: number of requesters, 2..8.
- IDW, 2: tag width, equal to ceil(log2(NREQ)).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_last  input  NREQ  per-requester last-beat-of-burst flag.
- req_ready  output  NREQ  per-requester accept; the beat transfers when valid and ready are both high.
- req_a  input  NREQ*(WIDTH+1)  packed A operands; requester i uses slice i.
- req_b  input  NREQ*(WIDTH+1)  packed B operands.
- add_a  output  WIDTH+1  A operand to the shared adder (combinational).
- add_b  output  WIDTH+1  B operand to the shared adder (combinational).
- add_sum  input  WIDTH+1  combinational sum returned by the shared adder.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_sum  output  WIDTH+1  registered sum.
- rsp_id  output  IDW  index of the requester that produced rsp_sum.

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_sum=0, rsp_id=0.
  - Round-robin pointer=0, FSM=IDLE, lock owner=0.
  - req_ready=0 while rst_n=0.
  - An in-flight result is discarded.
- Accept condition: acc = !rsp_valid || rsp_ready. The single output register empties and refills in the same cycle, giving one addition per cycle.
- Grant, combinational:
  - IDLE: grant the first req_valid at or after the pointer, searching upward with wrap from NREQ-1 to 0.
  - BURST: grant only the lock owner.
  - req_ready[i] = acc && grant[i]; at most one bit is set. All bits are 0 when acc=0 or there is no grant.
- Adder drive:
  - add_a/add_b = the granted requester's slices.
  - All zeros when nothing is granted, to limit toggling.
- Transfer edge (granted i with req_valid[i] && req_ready[i]):
  - rsp_sum <= add_sum, rsp_id <= i, rsp_valid <= 1.
  - Latency: 1 cycle from transfer to rsp_valid.
- Response drain: if rsp_valid && rsp_ready and no transfer that cycle, rsp_valid <= 0.
- Arithmetic: sum modulo 2^(WIDTH+1). Carry-out is dropped; there is no carry-in.
- FSM:
  - IDLE -> BURST on a transfer from i with req_last[i]=0; owner <= i.
  - IDLE stays IDLE on a transfer with req_last=1; pointer <= i+1 mod NREQ.
  - BURST stays BURST on an owner transfer with req_last=0.
  - BURST -> IDLE on an owner transfer with req_last=1; pointer <= owner+1 mod NREQ.
- Boundaries:
  - No requests: nothing is granted and the pointer is unchanged.
  - Owner drops req_valid mid-burst: the lock persists, other requesters stall, and there is no timeout.
  - rsp_ready=0 with rsp_valid=1: rsp_sum and rsp_id are held stable and all req_ready are 0.
  - A requester's operands must stay stable while req_valid=1 and req_ready=0.
  - rsp_ready is ignored when rsp_valid=0.

Optional Feature:
- Macro ADD49_SHARE_ARB_PRIO_EN.
- Defined:
  - In IDLE, requester 0 has fixed highest priority whenever req_valid[0]=1.
  - Otherwise round-robin is used over requesters 1..NREQ-1.
  - An active BURST lock is never pre-empted.
- Undefined: pure round-robin over all requesters, as above.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0000, rsp_valid=0, rsp_sum=0, rsp_id=0. Release, then req0 is granted first.
- Single request: req2 only, a=5, b=7, rsp_ready=1 -> req_ready=0100 in cycle T. At T+1: rsp_valid=1, rsp_sum=12, rsp_id=2.
- Fairness: all four requesters valid continuously with last=1, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1, one per cycle, with no bubbles.
- Wrap: a=0x1FFFFFFFFFFFF, b=1 -> rsp_sum=0. a=0x1FFFFFFFFFFFF, b=0x1FFFFFFFFFFFF -> rsp_sum=0x1FFFFFFFFFFFE.
- Backpressure: response pending, rsp_ready=0 for 3 cycles -> rsp_sum/rsp_id held and req_ready=0000. Raise rsp_ready -> the next grant transfers in the same cycle.
- Burst: req1 issues 3 beats with last=0,0,1 while req0 and req2 are valid -> rsp_id=1,1,1, then 2 (pointer=2), then 3 or 0 as valid. With PRIO_EN: the post-burst grant goes to 0.

Source files
------------

// File: rtl/add49_share_arb_if.sv
// Bus bundle for add49_share_arb. It carries the requester beats, the shared-adder operand and sum
// lines, and the tagged response channel. The slave modport is the arbiter side.
interface add49_share_arb_if #(
    parameter int WIDTH = 48,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_last;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ*(WIDTH+1)-1:0] req_a;
    logic [NREQ*(WIDTH+1)-1:0] req_b;
    logic [WIDTH:0]            add_a;
    logic [WIDTH:0]            add_b;
    logic [WIDTH:0]            add_sum;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [WIDTH:0]            rsp_sum;
    logic [IDW-1:0]            rsp_id;

    modport slave (
        input  req_valid, req_last, req_a, req_b, add_sum, rsp_ready,
        output req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_id
    );

    modport master (
        output req_valid, req_last, req_a, req_b, add_sum, rsp_ready,
        input  req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_id
    );
endinterface

// File: rtl/add49_share_arb.sv
// Round-robin arbiter that shares one external 49-bit adder among NREQ requesters and supports locked bursts.
// Define ADD49_SHARE_ARB_PRIO_EN to give requester 0 fixed priority whenever the arbiter is idle.
module add49_share_arb #(
    parameter int WIDTH = 48,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    add49_share_arb_if.slave bus
);
    localparam int W = WIDTH + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] rr_idx;
    logic           rr_vld;
    logic [IDW-1:0] grant_idx;
    logic           grant_vld;
    logic [IDW-1:0] next_idx;
    logic           acc;
    logic           xfer;
    logic           rsp_valid_q;
    logic [WIDTH:0] rsp_sum_q;
    logic [IDW-1:0] rsp_id_q;

    // The output register can take a new sum whenever it is empty or is being drained this cycle.
    assign acc  = !rsp_valid_q || bus.rsp_ready;
    assign xfer = acc && grant_vld;

    always_comb begin
        rr_vld = 1'b0;
        rr_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!rr_vld && bus.req_valid[(int'(ptr) + k) % NREQ]) begin
                rr_vld = 1'b1;
                rr_idx = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // A held lock admits only the owner. While the owner is not valid, every requester stalls.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (state == BURST) begin
            grant_vld = bus.req_valid[owner];
            grant_idx = owner;
        end else begin
`ifdef ADD49_SHARE_ARB_PRIO_EN
            if (bus.req_valid[0]) begin
                grant_vld = 1'b1;
                grant_idx = '0;
            end else begin
                grant_vld = rr_vld;
                grant_idx = rr_idx;
            end
`else
            grant_vld = rr_vld;
            grant_idx = rr_idx;
`endif
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (rst_n && acc && grant_vld) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    assign next_idx  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    assign bus.add_a = grant_vld ? bus.req_a[int'(grant_idx) * W +: W] : '0;
    assign bus.add_b = grant_vld ? bus.req_b[int'(grant_idx) * W +: W] : '0;

    // A beat with last=0 starts or keeps the lock. A last beat releases it and moves the pointer past the granted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
        end else if (xfer) begin
            rsp_valid_q <= 1'b1;
            rsp_sum_q   <= bus.add_sum;
            rsp_id_q    <= grant_idx;
            if (bus.req_last[grant_idx]) begin
                state <= IDLE;
                ptr   <= next_idx;
            end else begin
                state <= BURST;
                owner <= grant_idx;
            end
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_id    = rsp_id_q;
endmodule
